// File: rtl/fft_8.sv
// fft_8: fully pipelined 8-point radix-2 DIT FFT, eight unsigned 8-bit real samples in,
// eight complex bins out (low 8 bits of each part). Define FFT8_ROUND_EN to round the 1/sqrt(2) multiply.
module fft_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       out_valid,
    input  logic [7:0] a0,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] a3,
    input  logic [7:0] a4,
    input  logic [7:0] a5,
    input  logic [7:0] a6,
    input  logic [7:0] a7,
    output logic [7:0] xr0,
    output logic [7:0] xr1,
    output logic [7:0] xr2,
    output logic [7:0] xr3,
    output logic [7:0] xi0,
    output logic [7:0] xi1,
    output logic [7:0] xi2,
    output logic [7:0] xi3,
    output logic [7:0] xr4,
    output logic [7:0] xr5,
    output logic [7:0] xr6,
    output logic [7:0] xr7,
    output logic [7:0] xi4,
    output logic [7:0] xi5,
    output logic [7:0] xi6,
    output logic [7:0] xi7
);

    localparam int W = 20;
    typedef logic signed [W-1:0] sw_t;

    // Valid protocol: in_valid qualifies a0..a7 for exactly one edge and there is no
    // backpressure; out_valid pulses for one cycle per frame, two edges after the capture
    // edge. Stage registers and outputs load only on a valid frame and otherwise hold.

    // Multiply by 181/256 (about 1/sqrt(2)); arithmetic shift keeps negative values floored.
    function automatic sw_t scale(input sw_t v);
        sw_t p;
        p = v * sw_t'(181);
`ifdef FFT8_ROUND_EN
        p = p + sw_t'(128);
`endif
        return p >>> 8;
    endfunction

    // ------------------------------------------------------------------
    // Stage 1: length-2 butterflies on bit-reversed sample pairs
    // ------------------------------------------------------------------
    sw_t x [8];

    assign x[0] = sw_t'({12'd0, a0});
    assign x[1] = sw_t'({12'd0, a1});
    assign x[2] = sw_t'({12'd0, a2});
    assign x[3] = sw_t'({12'd0, a3});
    assign x[4] = sw_t'({12'd0, a4});
    assign x[5] = sw_t'({12'd0, a5});
    assign x[6] = sw_t'({12'd0, a6});
    assign x[7] = sw_t'({12'd0, a7});

    sw_t s1_a_d [4];
    sw_t s1_b_d [4];

    always_comb begin
        s1_a_d[0] = x[0] + x[4];
        s1_b_d[0] = x[0] - x[4];
        s1_a_d[1] = x[2] + x[6];
        s1_b_d[1] = x[2] - x[6];
        s1_a_d[2] = x[1] + x[5];
        s1_b_d[2] = x[1] - x[5];
        s1_a_d[3] = x[3] + x[7];
        s1_b_d[3] = x[3] - x[7];
    end

    sw_t  s1_a [4];
    sw_t  s1_b [4];
    logic s1_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s1_a[i] <= '0;
                s1_b[i] <= '0;
            end
        end else begin
            s1_v <= in_valid;
            if (in_valid) begin
                for (int i = 0; i < 4; i++) begin
                    s1_a[i] <= s1_a_d[i];
                    s1_b[i] <= s1_b_d[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: even 4-point sub-transform E[k] and twiddled odd terms T[k]
    // ------------------------------------------------------------------
    sw_t o0;
    sw_t o2;
    sw_t m1;
    sw_t m2;
    sw_t m3;
    sw_t s2_er_d [4];
    sw_t s2_ei_d [4];
    sw_t s2_tr_d [4];
    sw_t s2_ti_d [4];

    always_comb begin
        o0 = s1_a[2] + s1_a[3];
        o2 = s1_a[2] - s1_a[3];
        m1 = scale(s1_b[2] - s1_b[3]);
        m2 = scale(-(s1_b[2] + s1_b[3]));
        m3 = scale(s1_b[3] - s1_b[2]);

        // E0 = a0+a1, E1 = b0-j*b1, E2 = a0-a1, E3 = b0+j*b1
        s2_er_d[0] = s1_a[0] + s1_a[1];
        s2_ei_d[0] = '0;
        s2_er_d[1] = s1_b[0];
        s2_ei_d[1] = -s1_b[1];
        s2_er_d[2] = s1_a[0] - s1_a[1];
        s2_ei_d[2] = '0;
        s2_er_d[3] = s1_b[0];
        s2_ei_d[3] = s1_b[1];

        // T0 = O0, T1 = m1+j*m2, T2 = -j*O2, T3 = m3+j*m2
        s2_tr_d[0] = o0;
        s2_ti_d[0] = '0;
        s2_tr_d[1] = m1;
        s2_ti_d[1] = m2;
        s2_tr_d[2] = '0;
        s2_ti_d[2] = -o2;
        s2_tr_d[3] = m3;
        s2_ti_d[3] = m2;
    end

    sw_t  s2_er [4];
    sw_t  s2_ei [4];
    sw_t  s2_tr [4];
    sw_t  s2_ti [4];
    logic s2_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s2_er[i] <= '0;
                s2_ei[i] <= '0;
                s2_tr[i] <= '0;
                s2_ti[i] <= '0;
            end
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                for (int i = 0; i < 4; i++) begin
                    s2_er[i] <= s2_er_d[i];
                    s2_ei[i] <= s2_ei_d[i];
                    s2_tr[i] <= s2_tr_d[i];
                    s2_ti[i] <= s2_ti_d[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: final butterflies X[k] = E+T, X[k+4] = E-T, wrapped to 8 bits
    // ------------------------------------------------------------------
    logic [7:0] xr_q [8];
    logic [7:0] xi_q [8];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                xr_q[k] <= '0;
                xi_q[k] <= '0;
            end
        end else begin
            out_valid <= s2_v;
            if (s2_v) begin
                for (int k = 0; k < 4; k++) begin
                    xr_q[k]     <= 8'(s2_er[k] + s2_tr[k]);
                    xi_q[k]     <= 8'(s2_ei[k] + s2_ti[k]);
                    xr_q[k + 4] <= 8'(s2_er[k] - s2_tr[k]);
                    xi_q[k + 4] <= 8'(s2_ei[k] - s2_ti[k]);
                end
            end
        end
    end

    assign xr0 = xr_q[0];
    assign xr1 = xr_q[1];
    assign xr2 = xr_q[2];
    assign xr3 = xr_q[3];
    assign xr4 = xr_q[4];
    assign xr5 = xr_q[5];
    assign xr6 = xr_q[6];
    assign xr7 = xr_q[7];
    assign xi0 = xi_q[0];
    assign xi1 = xi_q[1];
    assign xi2 = xi_q[2];
    assign xi3 = xi_q[3];
    assign xi4 = xi_q[4];
    assign xi5 = xi_q[5];
    assign xi6 = xi_q[6];
    assign xi7 = xi_q[7];

endmodule

// File: tb/tb_fft_8.sv
// tb_fft_8: self-checking bench for fft_8; reference model is a direct 4-point DFT split
// with explicit twiddle products. Honours FFT8_ROUND_EN the same way as the design.
module tb_fft_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_valid;
    logic [7:0] a0 = '0, a1 = '0, a2 = '0, a3 = '0, a4 = '0, a5 = '0, a6 = '0, a7 = '0;
    logic [7:0] xr0, xr1, xr2, xr3, xr4, xr5, xr6, xr7;
    logic [7:0] xi0, xi1, xi2, xi3, xi4, xi5, xi6, xi7;

    int checks = 0;
    int errors = 0;

    // Packed result: xr[k] at bits [8k +: 8], xi[k] at bits [64 + 8k +: 8]
    logic [127:0] dut_out;
    logic [127:0] last_exp;
    logic [127:0] exp_q [$];
    logic         vld [64];
    logic [63:0]  frm [64];

    localparam logic [63:0]  IMP_FRAME = 64'h0000_0000_0000_0001;
    localparam logic [63:0]  DC_FRAME  = 64'h0A0A_0A0A_0A0A_0A0A;
    localparam logic [63:0]  MIX_FRAME = 64'h00C8_9600_6E00_8278;
    localparam logic [127:0] IMP_EXP   = {64'h0, 64'h0101_0101_0101_0101};
    localparam logic [127:0] DC_EXP    = {64'h0, 64'h0000_0000_0000_0050};
`ifdef FFT8_ROUND_EN
    localparam logic [127:0] MIX_EXP   = {64'h78AA_0800_F856_8800, 64'h1CB0_D4BA_D4B0_1CC6};
`else
    localparam logic [127:0] MIX_EXP   = {64'h78AA_0800_F856_8800, 64'h1DB0_D4BA_D3B0_1CC6};
`endif

    assign dut_out = {xi7, xi6, xi5, xi4, xi3, xi2, xi1, xi0,
                      xr7, xr6, xr5, xr4, xr3, xr2, xr1, xr0};

    fft_8 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .out_valid(out_valid),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
        .xr0(xr0), .xr1(xr1), .xr2(xr2), .xr3(xr3),
        .xi0(xi0), .xi1(xi1), .xi2(xi2), .xi3(xi3),
        .xr4(xr4), .xr5(xr5), .xr6(xr6), .xr7(xr7),
        .xi4(xi4), .xi5(xi5), .xi6(xi6), .xi7(xi7)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int s_mul(input int v);
`ifdef FFT8_ROUND_EN
        return (181 * v + 128) >>> 8;
`else
        return (181 * v) >>> 8;
`endif
    endfunction

    // X[k] = E[k] + W8^k O[k]; E/O are plain 4-point DFTs using (-j)^p,
    // and sqrt2*W8^1 = 1-j, sqrt2*W8^3 = -1-j before the 181/256 scaling.
    function automatic logic [127:0] fft_model(input logic [63:0] f);
        int x [8];
        int er [4];
        int ei [4];
        int orr [4];
        int oi [4];
        int tr [4];
        int ti [4];
        int cr [4] = '{1, 0, -1, 0};
        int ci [4] = '{0, -1, 0, 1};
        int p;
        logic [127:0] r;
        for (int n = 0; n < 8; n++) x[n] = int'(f[8*n +: 8]);
        for (int k = 0; k < 4; k++) begin
            er[k] = 0; ei[k] = 0; orr[k] = 0; oi[k] = 0;
            for (int m = 0; m < 4; m++) begin
                p = (m * k) % 4;
                er[k]  += x[2*m] * cr[p];
                ei[k]  += x[2*m] * ci[p];
                orr[k] += x[2*m+1] * cr[p];
                oi[k]  += x[2*m+1] * ci[p];
            end
        end
        tr[0] = orr[0];                 ti[0] = oi[0];
        tr[1] = s_mul(orr[1] + oi[1]);  ti[1] = s_mul(oi[1] - orr[1]);
        tr[2] = oi[2];                  ti[2] = -orr[2];
        tr[3] = s_mul(oi[3] - orr[3]);  ti[3] = s_mul(-orr[3] - oi[3]);
        for (int k = 0; k < 4; k++) begin
            r[8*k +: 8]          = 8'(er[k] + tr[k]);
            r[8*(k+4) +: 8]      = 8'(er[k] - tr[k]);
            r[64 + 8*k +: 8]     = 8'(ei[k] + ti[k]);
            r[64 + 8*(k+4) +: 8] = 8'(ei[k] - ti[k]);
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_frame();
        logic [63:0] f;
        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 5))
                0:       f[8*n +: 8] = 8'd0;
                1:       f[8*n +: 8] = 8'd255;
                default: f[8*n +: 8] = 8'($urandom_range(0, 255));
            endcase
        end
        return f;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [63:0] f);
        in_valid = v;
        a0 = f[7:0];   a1 = f[15:8];  a2 = f[23:16]; a3 = f[31:24];
        a4 = f[39:32]; a5 = f[47:40]; a6 = f[55:48]; a7 = f[63:56];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 64'hA5C3_17F0_0F71_3C5A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (dut_out !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h want 0", dut_out);
        end
        rst = 1'b0;
        drive(1'b0, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL post_reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (dut_out !== 128'h0) begin
            errors++; $display("FAIL post_reset_data got %h want 0", dut_out);
        end
        last_exp = 128'h0;
    endtask

    task automatic test_impulse();
        @(negedge clk);
        drive(1'b1, IMP_FRAME);
        @(negedge clk);
        drive(1'b0, 64'h0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL impulse_early_t got %b want 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL impulse_early_t1 got %b want 0", out_valid);
        end
        checks++;
        if (dut_out !== last_exp) begin
            errors++; $display("FAIL impulse_hold_before got %h want %h", dut_out, last_exp);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL impulse_valid_t2 got %b want 1", out_valid);
        end
        checks++;
        if (dut_out !== IMP_EXP) begin
            errors++; $display("FAIL impulse_data got %h want %h", dut_out, IMP_EXP);
        end
        checks++;
        if (dut_out !== fft_model(IMP_FRAME)) begin
            errors++; $display("FAIL impulse_model got %h want %h", dut_out, fft_model(IMP_FRAME));
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || dut_out !== IMP_EXP) begin
            errors++; $display("FAIL impulse_hold got v=%b %h want v=0 %h", out_valid, dut_out, IMP_EXP);
        end
        last_exp = IMP_EXP;
    endtask

    task automatic test_dc();
        @(negedge clk);
        drive(1'b1, DC_FRAME);
        @(negedge clk);
        drive(1'b0, 64'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL dc_valid got %b want 1", out_valid);
        end
        checks++;
        if (dut_out !== DC_EXP) begin
            errors++; $display("FAIL dc_data got %h want %h", dut_out, DC_EXP);
        end
        checks++;
        if (dut_out !== fft_model(DC_FRAME)) begin
            errors++; $display("FAIL dc_model got %h want %h", dut_out, fft_model(DC_FRAME));
        end
        last_exp = DC_EXP;
    endtask

    task automatic test_mixed();
        @(negedge clk);
        drive(1'b1, MIX_FRAME);
        @(negedge clk);
        drive(1'b0, 64'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL mixed_valid got %b want 1", out_valid);
        end
        checks++;
        if (dut_out !== MIX_EXP) begin
            errors++; $display("FAIL mixed_data got %h want %h", dut_out, MIX_EXP);
        end
        checks++;
        if (dut_out !== fft_model(MIX_FRAME)) begin
            errors++; $display("FAIL mixed_model got %h want %h", dut_out, fft_model(MIX_FRAME));
        end
        last_exp = MIX_EXP;
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        drive(1'b1, MIX_FRAME);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, DC_FRAME);
        @(negedge clk);
        checks++;
        if (dut_out !== 128'h0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL inflight_reset_clear got v=%b %h want v=0 0", out_valid, dut_out);
        end
        rst = 1'b0;
        drive(1'b0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || dut_out !== 128'h0) begin
                errors++; $display("FAIL inflight_flushed[%0d] got v=%b %h want v=0 0", i, out_valid, dut_out);
            end
        end
        last_exp = 128'h0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] held;
        logic [127:0] e;
        n = 9;
        for (int i = 0; i < n; i++) begin
            vld[i] = (i != 6);
            frm[i] = (i % 2 == 0) ? IMP_FRAME : DC_FRAME;
        end
        held = last_exp;
        exp_q.delete();
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (out_valid !== vld[c-3]) begin
                    errors++; $display("FAIL b2b_valid[%0d] got %b want %b", c - 3, out_valid, vld[c-3]);
                end
                if (vld[c-3]) begin
                    e = exp_q.pop_front();
                    held = e;
                end
                checks++;
                if (dut_out !== held) begin
                    errors++; $display("FAIL b2b_data[%0d] got %h want %h", c - 3, dut_out, held);
                end
            end
            if (c < n) begin
                drive(vld[c], frm[c]);
                if (vld[c]) exp_q.push_back((frm[c] == IMP_FRAME) ? IMP_EXP : DC_EXP);
            end else begin
                drive(1'b0, 64'h0);
            end
        end
        last_exp = held;
    endtask

    task automatic test_random();
        int n;
        logic [127:0] held;
        logic [127:0] e;
        n = 48;
        for (int i = 0; i < n; i++) begin
            vld[i] = ($urandom_range(0, 3) != 0);
            frm[i] = rand_frame();
        end
        held = last_exp;
        exp_q.delete();
        for (int c = 0; c <= n + 2; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (out_valid !== vld[c-3]) begin
                    errors++; $display("FAIL rand_valid[%0d] got %b want %b", c - 3, out_valid, vld[c-3]);
                end
                if (vld[c-3]) begin
                    e = exp_q.pop_front();
                    held = e;
                end
                checks++;
                if (dut_out !== held) begin
                    errors++; $display("FAIL rand_data[%0d] in=%h got %h want %h", c - 3, frm[c-3], dut_out, held);
                end
            end
            if (c < n) begin
                drive(vld[c], frm[c]);
                if (vld[c]) exp_q.push_back(fft_model(frm[c]));
            end else begin
                drive(1'b0, 64'h0);
            end
        end
        last_exp = held;
    endtask

    initial begin
        last_exp = 128'h0;
        test_reset();
        test_impulse();
        test_dc();
        test_mixed();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_8.md
# fft_8

Fixed-point 8-point radix-2 DIT FFT on eight unsigned 8-bit real samples, producing eight complex bins as 8-bit real and 8-bit imaginary words. Fully pipelined: one frame accepted per clock, three register stages. Used as the transform core fed by a sample-frame buffer and feeding spectrum post-processing.

## Interface
Parameters: none (widths fixed).
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  frame on a0..a7 valid this cycle
- a0..a7  input  8 each  unsigned time samples x[0]..x[7]
- out_valid  output  1  xr*/xi* hold a new frame
- xr0..xr7  output  8 each  Re X[k], low 8 bits of two's-complement result
- xi0..xi7  output  8 each  Im X[k], same rule
- Positional data-port order: a0..a7, xr0..xr3, xi0..xi3, xr4..xr7, xi4..xi7; clk, rst, in_valid, out_valid come first.

## Operation
- X[k] = sum x[n]·W^(nk), W = e^(-j2π/8). Internal math signed, ≥20 bits; no saturation; outputs truncated to low 8 bits (mod 256).
- Stage 1: a0=x0+x4, b0=x0−x4, a1=x2+x6, b1=x2−x6, a2=x1+x5, b2=x1−x5, a3=x3+x7, b3=x3−x7.
- Stage 2: E0=a0+a1, E2=a0−a1, E1=b0−j·b1, E3=b0+j·b1; O0=a2+a3, O2=a2−a3; S(v)=scaled constant multiply by 181/256 (≈1/√2); m1=S(b2−b3), m2=S(−(b2+b3)), m3=S(b3−b2).
- Twiddled odd terms: T0=O0, T2=−j·O2, T1=m1+j·m2, T3=m3+j·m2.
- Stage 3: X[k]=E[k]+T[k], X[k+4]=E[k]−T[k], k=0..3.
- Xi0 and Xi4 always 0.

## Timing
- 3-register pipeline, throughput 1 frame/clock, no backpressure.
- Frame sampled at edge t with in_valid=1 → stage regs at t, t+1; outputs and out_valid=1 registered at edge t+2.
- in_valid=0 → out_valid=0 two edges later; xr*/xi* hold last value.
- rst=1 at an edge: all pipeline data, all xr*/xi* = 0, out_valid=0, all in-flight valids cleared; rst has priority over in_valid. First frame after reset released at edge t obeys normal latency.
- Back-to-back frames emerge back-to-back in order.

## Configuration
- FFT8_ROUND_EN defined: S(v) = (181·v + 128) >>> 8 (round to nearest, arithmetic shift).
- Not defined: S(v) = (181·v) >>> 8 (floor).
- Only S differs; everything else identical.

## Test plan
- Reset: rst=1 with in_valid=1 and nonzero data → all outputs 0, out_valid 0; remain 0 two edges after rst falls if in_valid=0.
- Impulse x0=1, rest 0 → all xr=1, all xi=0, out_valid exactly 3rd edge after sample (edge t+2).
- DC all x=10 → xr0=80, every other xr/xi 0.
- Mixed frame x=(120,130,0,110,0,150,200,0), FFT8_ROUND_EN defined → xr0..7 = 198,28,176,212,186,212,176,28; xi0..7 = 0,136,86,248,0,8,170,120.
- Same frame, FFT8_ROUND_EN undefined → xr3=211, xr7=29; all other outputs as above.
- Streaming: alternate impulse/DC frames every cycle, then in_valid low one cycle → outputs alternate in order, out_valid drops for exactly one cycle, values held.
